// File: rtl/div_tick_feeder.sv
// div_tick_feeder: releases one buffered word per rising edge of divided (both edges when TICK_BOTH_EDGES_EN is defined)
module div_tick_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              divided,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic [UCNT_W-1:0] underrun_cnt
);
  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  state_t            state, state_nxt;
  logic              div_q, tick, wr, rd;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef TICK_BOTH_EDGES_EN
  assign tick = divided ^ div_q;
`else
  assign tick = divided & ~div_q;
`endif
  assign in_ready = state != FULL;
  assign wr = in_valid & in_ready;
  assign rd = tick & (fifo_count != '0);
  // next occupancy and the status state it implies
  always_comb begin
    cnt_nxt = fifo_count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
    state_nxt = cnt_nxt == '0 ? EMPTY : cnt_nxt == CNT_FULL ? FULL : HOLD;
  end
  // word storage, written only while out of reset
  always_ff @(posedge clk)
    if (wr && !rst) mem[wr_ptr] <= in_data;
  // pointers, occupancy, issue pulse and underrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= 1'b1;
      state        <= EMPTY;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      underrun_cnt <= '0;
    end else begin
      div_q      <= divided;
      state      <= state_nxt;
      fifo_count <= cnt_nxt;
      out_valid  <= rd;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_data <= mem[rd_ptr];
      end
      if (tick && fifo_count == '0 && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule
